// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Produces pixel coordinates, an active-area flag, sync/blank outputs delayed
// by a configurable pipeline, and line/frame event pulses with a frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIPE     = 2,
    parameter int CW       = 10
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          enable,
    output logic [CW-1:0] x_count,
    output logic [CW-1:0] y_count,
    output logic          display_area,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_blank_n,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] X_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] X_HS0   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] X_HS1   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] Y_VS0   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] Y_VS1   = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON  = (HS_POL != 0);
    localparam logic HS_OFF = !HS_ON;
    localparam logic VS_ON  = (VS_POL != 0);
    localparam logic VS_OFF = !VS_ON;

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [15:0]   fc_q, fc_d;
    logic          disp_q, disp_d;
    logic          ls_q, ls_d, fs_q, fs_d;
    logic          hs_raw, vs_raw, blank_raw;

    // Next raster position, event pulses and frame counter.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (enable) begin
            if (x_q == X_LAST) begin
                x_d  = '0;
                ls_d = 1'b1;
                if (y_q == Y_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                    fc_d = fc_q + 16'd1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        // Computed from the next position so it lines up with the registered counters.
        disp_d = (x_d < X_ACT) && (y_d < Y_ACT);
    end

    // Raster state registers; reset lands on the active origin without a pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q    <= '0;
            y_q    <= '0;
            fc_q   <= '0;
            disp_q <= 1'b1;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            fc_q   <= fc_d;
            disp_q <= disp_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    // Undelayed sync/blank decoded from the registered position.
    always_comb begin
        hs_raw    = (x_q >= X_HS0 && x_q < X_HS1) ? HS_ON : HS_OFF;
        vs_raw    = (y_q >= Y_VS0 && y_q < Y_VS1) ? VS_ON : VS_OFF;
        blank_raw = disp_q;
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            assign vga_hs      = hs_raw;
            assign vga_vs      = vs_raw;
            assign vga_blank_n = blank_raw;
        end else begin : g_pipe
            logic [PIPE-1:0] hs_pipe_q, hs_pipe_d;
            logic [PIPE-1:0] vs_pipe_q, vs_pipe_d;
            logic [PIPE-1:0] bl_pipe_q, bl_pipe_d;

            // Delay line advances only on enabled pixel clocks.
            always_comb begin
                hs_pipe_d = hs_pipe_q;
                vs_pipe_d = vs_pipe_q;
                bl_pipe_d = bl_pipe_q;
                if (enable) begin
                    hs_pipe_d[0] = hs_raw;
                    vs_pipe_d[0] = vs_raw;
                    bl_pipe_d[0] = blank_raw;
                    for (int i = 1; i < PIPE; i++) begin
                        hs_pipe_d[i] = hs_pipe_q[i-1];
                        vs_pipe_d[i] = vs_pipe_q[i-1];
                        bl_pipe_d[i] = bl_pipe_q[i-1];
                    end
                end
            end

            // Delay registers reset to inactive sync and blanked video.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    hs_pipe_q <= {PIPE{HS_OFF}};
                    vs_pipe_q <= {PIPE{VS_OFF}};
                    bl_pipe_q <= '0;
                end else begin
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                    bl_pipe_q <= bl_pipe_d;
                end
            end

            assign vga_hs      = hs_pipe_q[PIPE-1];
            assign vga_vs      = vs_pipe_q[PIPE-1];
            assign vga_blank_n = bl_pipe_q[PIPE-1];
        end
    endgenerate

    assign x_count      = x_q;
    assign y_count      = y_q;
    assign display_area = disp_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign frame_count  = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-raster instances (PIPE=0, PIPE=3,
// inverted polarity with PIPE=2) checked against a count-of-enabled-pixels model.
module tb_vga_timing_gen;

    localparam int HT = 15;   // 8+2+3+2
    localparam int VT = 8;    // 4+1+2+1
    localparam int FT = HT * VT;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic enable = 1'b0;

    logic [3:0]  xc [3];
    logic [3:0]  yc [3];
    logic        da [3];
    logic        hs [3];
    logic        vs [3];
    logic        bn [3];
    logic        ls [3];
    logic        fs [3];
    logic [15:0] fc [3];

    int pipe_of [3] = '{0, 3, 2};
    int hpol_of [3] = '{0, 0, 1};
    int vpol_of [3] = '{0, 0, 1};

    int checks = 0;
    int failures = 0;

    // Model state: enabled pixel edges since the last reset, and whether the last edge was enabled.
    int   n = 0;
    logic last_en = 1'b0;

    always #5 clock = ~clock;

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(0), .VS_POL(0), .PIPE(0), .CW(4)) u_p0 (
        .clock(clock), .resetn(resetn), .enable(enable),
        .x_count(xc[0]), .y_count(yc[0]), .display_area(da[0]),
        .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_blank_n(bn[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fc[0]));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(0), .VS_POL(0), .PIPE(3), .CW(4)) u_p3 (
        .clock(clock), .resetn(resetn), .enable(enable),
        .x_count(xc[1]), .y_count(yc[1]), .display_area(da[1]),
        .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_blank_n(bn[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fc[1]));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(1), .VS_POL(1), .PIPE(2), .CW(4)) u_pol (
        .clock(clock), .resetn(resetn), .enable(enable),
        .x_count(xc[2]), .y_count(yc[2]), .display_area(da[2]),
        .vga_hs(hs[2]), .vga_vs(vs[2]), .vga_blank_n(bn[2]),
        .line_start(ls[2]), .frame_start(fs[2]), .frame_count(fc[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    function automatic int xpos(input int m); return m % HT; endfunction
    function automatic int ypos(input int m); return (m / HT) % VT; endfunction
    function automatic logic hs_act(input int m); return xpos(m) >= 10 && xpos(m) <= 12; endfunction
    function automatic logic vs_act(input int m); return ypos(m) >= 5 && ypos(m) <= 6; endfunction
    function automatic logic vis(input int m); return xpos(m) < 8 && ypos(m) < 4; endfunction

    // Compare every output of every instance against the raster model.
    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            logic ehs, evs, ebn, els;
            int   p;
            p = pipe_of[d];
            if (n >= p) begin
                ehs = hs_act(n - p) ? hpol_of[d][0] : !hpol_of[d][0];
                evs = vs_act(n - p) ? vpol_of[d][0] : !vpol_of[d][0];
                ebn = vis(n - p);
            end else begin
                ehs = !hpol_of[d][0];
                evs = !vpol_of[d][0];
                ebn = 1'b0;
            end
            els = last_en && n > 0 && xpos(n) == 0;
            chk($sformatf("x%0d", d),  32'(xc[d]), 32'(xpos(n)));
            chk($sformatf("y%0d", d),  32'(yc[d]), 32'(ypos(n)));
            chk($sformatf("da%0d", d), 32'(da[d]), 32'(vis(n)));
            chk($sformatf("hs%0d", d), 32'(hs[d]), 32'(ehs));
            chk($sformatf("vs%0d", d), 32'(vs[d]), 32'(evs));
            chk($sformatf("bn%0d", d), 32'(bn[d]), 32'(ebn));
            chk($sformatf("ls%0d", d), 32'(ls[d]), 32'(els));
            chk($sformatf("fs%0d", d), 32'(fs[d]), 32'(els && ypos(n) == 0));
            chk($sformatf("fc%0d", d), 32'(fc[d]), 32'((n / FT) % 65536));
        end
    endtask

    // One clock: drive enable, advance the model at the edge, check at the falling edge.
    task automatic tick(input logic en);
        enable = en;
        @(posedge clock);
        if (resetn && en) n++;
        last_en = resetn && en;
        @(negedge clock);
        check_all();
    endtask

    initial begin
        int guard;
        // Reset held for three clocks.
        resetn = 1'b0;
        repeat (3) tick(1'b1);
        chk("rst_hs_lowpol", 32'(hs[0]), 32'd1);
        chk("rst_vs_highpol", 32'(vs[2]), 32'd0);
        chk("rst_da", 32'(da[0]), 32'd1);
        @(negedge clock);
        resetn = 1'b1;

        // Alternating enable: hsync reached after 20 clocks (10 enabled pixels).
        for (int i = 0; i < 20; i++) tick(i % 2 == 0);
        chk("tog_x", 32'(xc[0]), 32'd10);
        chk("tog_hs", 32'(hs[0]), 32'd0);

        // Free-running to the first and second frame wrap.
        guard = 0;
        while (n < FT && guard < 1000) begin tick(1'b1); guard++; end
        chk("frame1_fs", 32'(fs[0]), 32'd1);
        chk("frame1_fc", 32'(fc[0]), 32'd1);
        while (n < 2 * FT && guard < 1000) begin tick(1'b1); guard++; end
        chk("frame2_fc", 32'(fc[1]), 32'd2);
        chk("frame2_ls", 32'(ls[1]), 32'd1);

        // Random pixel strobe.
        for (int i = 0; i < 400; i++) tick(1'(($urandom & 32'h3) != 0));

        // Steer into x=11,y=5 (inside both syncs) and reset mid-cycle.
        guard = 0;
        while (n % FT != 5 * HT + 11 && guard < 200) begin tick(1'b1); guard++; end
        chk("reach_sync", 32'(guard < 200), 32'd1);
        chk("in_sync_hs0", 32'(hs[0]), 32'd0);
        #2 resetn = 1'b0;
        #1;
        n = 0;
        last_en = 1'b0;
        check_all();
        chk("async_hs_pol1", 32'(hs[2]), 32'd0);
        repeat (2) tick(1'b1);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 2 * FT + 5; i++) tick(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
